// File: rtl/rotary_pkg.sv
// Shared types and constants for the rotary parameter bank: button FSM states,
// step direction encoding and the fast-turn step multiplier.
package rotary_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DB_PRESS,
      PRESSED,
      DB_RELEASE
   } btnState_t;

   localparam logic DIR_DOWN   = 1'b0;
   localparam logic DIR_UP     = 1'b1;
   localparam int   ACCEL_MULT = 4;

   // Cycles after reset during which encoder edges are ignored.
   localparam logic [1:0] ARM_CYCLES = 2'd3;

endpackage

// File: rtl/rotary_step_decoder.sv
// Synchronises the encoder and button pins and turns quadrature edges into
// single-cycle step pulses with a direction; steps are masked just after reset.
module rotary_step_decoder
   import rotary_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic quadA,
   input  logic quadB,
   input  logic button,
   output logic step,
   output logic dir,
   output logic btnLevel
);

   // bit0 = s0, bit1 = s1, bit2 = history s2
   logic [2:0] aHist;
   logic [2:0] bHist;
   logic [1:0] btnSync;
   logic [1:0] armCnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         aHist   <= '0;
         bHist   <= '0;
         btnSync <= '0;
         armCnt  <= ARM_CYCLES;
      end else begin
         aHist   <= {aHist[1:0], quadA};
         bHist   <= {bHist[1:0], quadB};
         btnSync <= {btnSync[0], button};
         if (armCnt != 2'd0)
            armCnt <= armCnt - 2'd1;
      end
   end

   assign step     = (armCnt == 2'd0) && (aHist[1] ^ aHist[2] ^ bHist[1] ^ bHist[2]);
   assign dir      = (aHist[2] ^ bHist[1]) ? DIR_UP : DIR_DOWN;
   assign btnLevel = btnSync[1];

endmodule

// File: rtl/rotary_param_bank.sv
// One encoder + one button shared across NUM_PARAMS saturating parameter registers.
// Optional ROTARY_ACCEL_EN: quick same-direction turns use ACCEL_MULT times the step.
module rotary_param_bank
   import rotary_pkg::*;
#(
   parameter  int NUM_PARAMS      = 4,
   parameter  int WIDTH           = 12,
   parameter  int INC             = 32,
   parameter  int INIT_VALUE      = 2048,
   parameter  int DEBOUNCE_CYCLES = 65536,
   parameter  int ACCEL_WINDOW    = 200000,
   localparam int SEL_W           = $clog2(NUM_PARAMS)
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        quadA,
   input  logic                        quadB,
   input  logic                        button,
   output logic [NUM_PARAMS*WIDTH-1:0] values,
   output logic [SEL_W-1:0]            sel,
   output logic                        changed,
   output logic [SEL_W-1:0]            changed_idx
);

   localparam int EW   = WIDTH + 3;
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [EW-1:0] MAX_V = {3'b000, {WIDTH{1'b1}}};

   if (NUM_PARAMS < 2 || NUM_PARAMS > 16 || DEBOUNCE_CYCLES < 2 || ACCEL_WINDOW < 1) begin : gBadCfg
      $error("rotary_param_bank: parameter out of range");
   end

   function automatic logic [WIDTH-1:0] satStep(input logic [WIDTH-1:0] v,
                                                input logic             up,
                                                input logic [EW-1:0]    s);
      logic [EW-1:0] ve;
      ve = EW'(v);
      if (up)
         satStep = (ve > MAX_V - s) ? {WIDTH{1'b1}} : WIDTH'(ve + s);
      else
         satStep = (ve < s) ? '0 : WIDTH'(ve - s);
   endfunction

   logic step;
   logic dir;
   logic btnLevel;

   rotary_step_decoder uDecoder (
      .clk      (clk),
      .rst      (rst),
      .quadA    (quadA),
      .quadB    (quadB),
      .button   (button),
      .step     (step),
      .dir      (dir),
      .btnLevel (btnLevel)
   );

   logic [EW-1:0] stepSize;

`ifdef ROTARY_ACCEL_EN
   localparam int GAP_W = $clog2(ACCEL_WINDOW + 1);
   logic [GAP_W-1:0] gapCnt;
   logic             lastDir;

   // Gap starts saturated so the first step after reset is always slow.
   always_ff @(posedge clk) begin
      if (rst) begin
         gapCnt  <= GAP_W'(ACCEL_WINDOW);
         lastDir <= DIR_UP;
      end else if (step) begin
         gapCnt  <= '0;
         lastDir <= dir;
      end else if (gapCnt != GAP_W'(ACCEL_WINDOW)) begin
         gapCnt  <= gapCnt + GAP_W'(1);
      end
   end

   assign stepSize = ((gapCnt < GAP_W'(ACCEL_WINDOW)) && (dir == lastDir))
                   ? EW'(ACCEL_MULT * INC) : EW'(INC);
`else
   assign stepSize = EW'(INC);
`endif

   logic [WIDTH-1:0] bank [NUM_PARAMS];
   logic [WIDTH-1:0] curVal;
   logic [WIDTH-1:0] nextVal;
   logic             writeEn;

   assign curVal  = bank[sel];
   assign nextVal = satStep(curVal, dir, stepSize);
   assign writeEn = step && (nextVal != curVal);

   // Write stage: uses sel as it stood before any same-edge advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PARAMS; i++)
            bank[i] <= WIDTH'(INIT_VALUE);
         changed     <= 1'b0;
         changed_idx <= '0;
      end else begin
         changed <= writeEn;
         if (writeEn) begin
            bank[sel]   <= nextVal;
            changed_idx <= sel;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : gFlatten
      assign values[gi*WIDTH +: WIDTH] = bank[gi];
   end

   btnState_t        state;
   btnState_t        stateNext;
   logic [DB_W-1:0]  dbCnt;
   logic [DB_W-1:0]  dbCntNext;
   logic             dbDone;
   logic             selAdv;

   assign dbDone = (dbCnt == DB_W'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         dbCnt <= '0;
         sel   <= '0;
      end else begin
         state <= stateNext;
         dbCnt <= dbCntNext;
         if (selAdv)
            sel <= (sel == SEL_W'(NUM_PARAMS - 1)) ? '0 : sel + SEL_W'(1);
      end
   end

   // Counter restarts from zero on every state entry.
   always_comb begin
      stateNext = state;
      dbCntNext = dbCnt;
      selAdv    = 1'b0;
      case (state)
         IDLE: begin
            if (btnLevel) begin
               stateNext = DB_PRESS;
               dbCntNext = '0;
            end
         end
         DB_PRESS: begin
            if (!btnLevel) begin
               stateNext = IDLE;
               dbCntNext = '0;
            end else if (dbDone) begin
               stateNext = PRESSED;
               dbCntNext = '0;
               selAdv    = 1'b1;
            end else begin
               dbCntNext = dbCnt + DB_W'(1);
            end
         end
         PRESSED: begin
            if (!btnLevel) begin
               stateNext = DB_RELEASE;
               dbCntNext = '0;
            end
         end
         DB_RELEASE: begin
            if (btnLevel) begin
               stateNext = PRESSED;
               dbCntNext = '0;
            end else if (dbDone) begin
               stateNext = IDLE;
               dbCntNext = '0;
            end else begin
               dbCntNext = dbCnt + DB_W'(1);
            end
         end
         default: begin
            stateNext = IDLE;
            dbCntNext = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_rotary_param_bank.sv
// Scoreboard bench for rotary_param_bank; expected writes are queued when encoder
// edges are driven and retired on each changed pulse. Honours ROTARY_ACCEL_EN.
`timescale 1ns/1ps
module tb_rotary_param_bank;

   localparam int NP    = 4;
   localparam int W     = 12;
   localparam int INC_V = 32;
   localparam int INIT  = 2048;
   localparam int DB    = 16;
   localparam int WIN   = 2000;
   localparam int MAXV  = (1 << W) - 1;
   localparam int SW    = $clog2(NP);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              quadA = 1'b0;
   logic              quadB = 1'b0;
   logic              button = 1'b0;
   logic [NP*W-1:0]   values;
   logic [SW-1:0]     sel;
   logic              changed;
   logic [SW-1:0]     changed_idx;

   rotary_param_bank #(
      .NUM_PARAMS      (NP),
      .WIDTH           (W),
      .INC             (INC_V),
      .INIT_VALUE      (INIT),
      .DEBOUNCE_CYCLES (DB),
      .ACCEL_WINDOW    (WIN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .quadA       (quadA),
      .quadB       (quadB),
      .button      (button),
      .values      (values),
      .sel         (sel),
      .changed     (changed),
      .changed_idx (changed_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int val;
   } exp_t;

   exp_t expQ[$];
   int   errCnt = 0;
   int   chkCnt = 0;
   int   chgCnt = 0;
   int   cyc    = 0;
   int   mv [NP];
   int   msel;
   int   gpos   = 0;
`ifdef ROTARY_ACCEL_EN
   bit   havePrev = 1'b0;
   int   prevCyc  = 0;
   bit   prevUp   = 1'b0;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      chkCnt++;
      if (act !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      for (int i = 0; i < NP; i++) mv[i] = INIT;
      msel = 0;
      expQ.delete();
`ifdef ROTARY_ACCEL_EN
      havePrev = 1'b0;
`endif
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick(2);
      modelReset();
      rst = 1'b0;
      tick(4);
   endtask

   task automatic encStep(input bit up, input int gapAfter);
      int   s;
      int   oldV;
      int   newV;
      exp_t e;
      gpos = up ? (gpos + 1) % 4 : (gpos + 3) % 4;
      case (gpos)
         0:       begin quadA = 1'b0; quadB = 1'b0; end
         1:       begin quadA = 1'b0; quadB = 1'b1; end
         2:       begin quadA = 1'b1; quadB = 1'b1; end
         default: begin quadA = 1'b1; quadB = 1'b0; end
      endcase
      s = INC_V;
`ifdef ROTARY_ACCEL_EN
      if (havePrev && (cyc - prevCyc - 1) < WIN && up == prevUp) s = 4 * INC_V;
      havePrev = 1'b1;
      prevCyc  = cyc;
      prevUp   = up;
`endif
      oldV = mv[msel];
      if (up) newV = (oldV + s > MAXV) ? MAXV : oldV + s;
      else    newV = (oldV < s) ? 0 : oldV - s;
      if (newV != oldV) begin
         mv[msel] = newV;
         e.idx = msel;
         e.val = newV;
         expQ.push_back(e);
      end
      tick(gapAfter);
   endtask

   task automatic press(input int bounce, input int hold);
      for (int i = 0; i < bounce; i++) begin
         button = ~button;
         tick(1);
      end
      button = 1'b1;
      tick(hold);
      for (int i = 0; i < bounce; i++) begin
         button = ~button;
         tick(1);
      end
      button = 1'b0;
      tick(DB + 10);
      msel = (msel + 1) % NP;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 50 && expQ.size() > 0; i++) tick(1);
      chk(tag, expQ.size(), 0);
      tick(2);
   endtask

   always @(negedge clk) begin
      if (!rst && changed) begin
         chgCnt++;
         if (expQ.size() == 0) begin
            chk("unexp_changed", changed, 1'b0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            chk("chg_idx", changed_idx, e.idx);
            chk("chg_val", values[e.idx*W +: W], e.val);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      modelReset();
      tick(3);
      rst = 1'b0;
      chk("rst_values", values, {NP{12'd2048}});
      chk("rst_sel", sel, 0);
      chk("rst_changed", changed, 0);
      chk("rst_changed_idx", changed_idx, 0);
      tick(4);

      // three CW detents on param 0
      chgCnt = 0;
      for (int i = 0; i < 12; i++) encStep(1'b1, 4);
      drain("drain_cw");
`ifdef ROTARY_ACCEL_EN
      chk("cw_v0", values[0 +: W], 2048 + 32 + 11 * 128);
`else
      chk("cw_v0", values[0 +: W], 2432);
`endif
      chk("cw_others", values[W +: 3*W], {3{12'd2048}});
      chk("cw_pulses", chgCnt, 12);

      // button: bounced long press, then wrap-around
      press(10, 70);
      chk("sel_after_1", sel, msel);
      chk("sel_one_adv", sel, 1);
      press(0, 40);
      chk("sel_after_2", sel, 2);
      press(3, 40);
      chk("sel_after_3", sel, 3);
      press(0, 40);
      chk("sel_wrap", sel, 0);

      // step lands on the same edge the debounce completes
      button = 1'b1;
      tick(DB);
      encStep(1'b1, 6);
      msel = 1;
      chk("sim_sel", sel, 1);
      button = 1'b0;
      tick(DB + 10);
      encStep(1'b1, 6);
      drain("drain_sim");
      chk("sim_sel_after", sel, 1);

      // reset in the middle of a debounce
      button = 1'b1;
      tick(8);
      rst = 1'b1;
      button = 1'b0;
      tick(2);
      modelReset();
      rst = 1'b0;
      tick(DB + 10);
      chk("middb_sel", sel, 0);
      chk("middb_values", values, {NP{12'd2048}});

      // rails
      for (int i = 0; i < 70; i++) encStep(1'b1, 3);
      drain("drain_up_rail");
      chk("rail_max", values[0 +: W], MAXV);
      for (int i = 0; i < 130; i++) encStep(1'b0, 3);
      drain("drain_dn_rail");
      chk("rail_zero", values[0 +: W], 0);

      // pins high through reset release
      rst = 1'b1;
      gpos = 2;
      quadA = 1'b1;
      quadB = 1'b1;
      tick(2);
      modelReset();
      chgCnt = 0;
      rst = 1'b0;
      tick(10);
      chk("arm_v0", values[0 +: W], 2048);
      chk("arm_pulses", chgCnt, 0);
      encStep(1'b1, 6);
      drain("drain_arm");
      chk("arm_first_step", values[0 +: W], 2080);

      // step spacing: 1000 cycles, then 3000 cycles
      quadA = 1'b0;
      quadB = 1'b0;
      gpos = 0;
      doReset();
      for (int i = 0; i < 5; i++) encStep(1'b1, 1000);
      tick(2000);
      for (int i = 0; i < 3; i++) encStep(1'b1, 3000);
      drain("drain_accel");
`ifdef ROTARY_ACCEL_EN
      chk("accel_v0", values[0 +: W], 2688);
`else
      chk("accel_v0", values[0 +: W], 2304);
`endif

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
